page_controller: RTL and testbench

//   Top-level page scheduler for the VGA UI. Debounces the 4 push keys and runs the page FSM (MAIN/PLAY/PAUSE/OVER).

---
 rtl/page_ctrl_pkg.sv | 32 +++
 rtl/page_controller_key_debounce.sv | 54 +++++
 rtl/page_controller.sv | 140 ++++++++++++++
 tb/tb_page_controller.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_ctrl_pkg.sv
// Shared constants and page encoding for the VGA page controller.
// Optional fade-in after page switches is enabled by PAGE_FADE_EN.
package page_ctrl_pkg;

    localparam logic [1:0] PAGE_MAIN  = 2'd0;
    localparam logic [1:0] PAGE_PLAY  = 2'd1;
    localparam logic [1:0] PAGE_PAUSE = 2'd2;
    localparam logic [1:0] PAGE_OVER  = 2'd3;

    typedef enum logic [1:0] {
        ST_MAIN  = PAGE_MAIN,
        ST_PLAY  = PAGE_PLAY,
        ST_PAUSE = PAGE_PAUSE,
        ST_OVER  = PAGE_OVER
    } page_e;

    localparam int NUM_KEYS    = 4;
    localparam int KEY_CONFIRM = 0;
    localparam int KEY_BACK    = 1;
    localparam int KEY_UP      = 2;
    localparam int KEY_DOWN    = 3;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam int PIX_W = 12;
    localparam int CH_W  = 4;
    localparam int R_LSB = 0;
    localparam int G_LSB = 4;
    localparam int B_LSB = 8;

endpackage

// File: rtl/page_controller_key_debounce.sv
// Single-key debouncer: 2-flop synchroniser, stability counter and
// registered rising-edge pulse of the accepted level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic pulse
);

    localparam int CW =
        (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          pulse_q;

    // Any sample matching the accepted level restarts the count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], key_raw};
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            pulse_q      <= stable_q & ~stable_dly_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/page_controller.sv
// VGA UI page scheduler: key debounce, page FSM, frame-aligned commit
// and registered pixel mux. PAGE_FADE_EN adds post-switch dimming.
module page_controller
    import page_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef PAGE_FADE_EN
    ,
    parameter int FADE_FRAMES = 3
`endif
) (
    input  logic             vga_clk,
    input  logic             vga_rst_n,
    input  logic [3:0]       keys,
    input  logic             frame_done,
    input  logic             game_over,
    input  logic [PIX_W-1:0] pix_main,
    input  logic [PIX_W-1:0] pix_play,
    input  logic [PIX_W-1:0] pix_pause,
    input  logic [PIX_W-1:0] pix_over,
    output logic [1:0]       page_sel,
    output logic [3:0]       key_pulse,
    output logic             page_changed,
    output logic [PIX_W-1:0] pixel_data
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (vga_clk),
            .rst_n  (vga_rst_n),
            .key_raw(keys[k]),
            .pulse  (key_pulse[k])
        );
    end

    page_e            pending_q, pending_d;
    page_e            sel_q, sel_d;
    logic             changed_q, changed_d;
    logic [PIX_W-1:0] pix_sel, pix_d, pix_q;
    logic             confirm, back;

    assign confirm = key_pulse[KEY_CONFIRM];
    assign back    = key_pulse[KEY_BACK];

    // Transitions listed per state in priority order.
    always_comb begin
        pending_d = pending_q;
        unique case (pending_q)
            ST_MAIN: begin
                if (confirm) pending_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (game_over) pending_d = ST_OVER;
                else if (back) pending_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (confirm)   pending_d = ST_PLAY;
                else if (back) pending_d = ST_MAIN;
            end
            ST_OVER: begin
                if (confirm) pending_d = ST_MAIN;
            end
            default: pending_d = pending_q;
        endcase
    end

    always_comb begin
        sel_d     = sel_q;
        changed_d = 1'b0;
        if (frame_done) begin
            sel_d     = pending_q;
            changed_d = (pending_q != sel_q);
        end
    end

    always_comb begin
        pix_sel = pix_main;
        unique case (sel_q)
            ST_MAIN:  pix_sel = pix_main;
            ST_PLAY:  pix_sel = pix_play;
            ST_PAUSE: pix_sel = pix_pause;
            ST_OVER:  pix_sel = pix_over;
            default:  pix_sel = pix_main;
        endcase
    end

`ifdef PAGE_FADE_EN
    localparam int FW =
        (FADE_FRAMES < 2) ? 1 : $clog2(FADE_FRAMES + 1);

    logic [FW-1:0] fade_q, fade_d;

    always_comb begin
        fade_d = fade_q;
        if (frame_done) begin
            if (pending_q != sel_q) begin
                fade_d = FW'(FADE_FRAMES);
            end else if (fade_q != '0) begin
                fade_d = fade_q - 1'b1;
            end
        end
    end

    // Oversized shifts drain the channel to zero.
    always_comb begin
        pix_d = '0;
        pix_d[R_LSB +: CH_W] = pix_sel[R_LSB +: CH_W] >> fade_q;
        pix_d[G_LSB +: CH_W] = pix_sel[G_LSB +: CH_W] >> fade_q;
        pix_d[B_LSB +: CH_W] = pix_sel[B_LSB +: CH_W] >> fade_q;
    end

    always_ff @(posedge vga_clk) begin
        if (!vga_rst_n) fade_q <= '0;
        else            fade_q <= fade_d;
    end
`else
    assign pix_d = pix_sel;
`endif

    always_ff @(posedge vga_clk) begin
        if (!vga_rst_n) begin
            pending_q <= ST_MAIN;
            sel_q     <= ST_MAIN;
            changed_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            pending_q <= pending_d;
            sel_q     <= sel_d;
            changed_q <= changed_d;
            pix_q     <= pix_d;
        end
    end

    assign page_sel     = sel_q;
    assign page_changed = changed_q;
    assign pixel_data   = pix_q;

endmodule

// File: tb/tb_page_controller.sv
// Self-checking bench for page_controller (DEBOUNCE_CYCLES=4), with a
// window-based debounce model and table-driven page model.
module tb_page_controller;

    localparam int N    = 4;
    localparam int FADE = 3;
    localparam int MAIN = 0, PLAY = 1, PAUSE = 2, OVER = 3;

    // Next page per page for events {game_over, confirm, back},
    // searched in that priority order; -1 means no transition.
    localparam int TRANS [4][3] = '{
        '{-1,   PLAY, -1},
        '{OVER, -1,   PAUSE},
        '{-1,   PLAY, MAIN},
        '{-1,   MAIN, -1}
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  keys;
    logic        frame_done;
    logic        game_over;
    logic [11:0] pix_main, pix_play, pix_pause, pix_over;
    logic [1:0]  page_sel;
    logic [3:0]  key_pulse;
    logic        page_changed;
    logic [11:0] pixel_data;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    page_controller #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .vga_clk     (clk),
        .vga_rst_n   (rst_n),
        .keys        (keys),
        .frame_done  (frame_done),
        .game_over   (game_over),
        .pix_main    (pix_main),
        .pix_play    (pix_play),
        .pix_pause   (pix_pause),
        .pix_over    (pix_over),
        .page_sel    (page_sel),
        .key_pulse   (key_pulse),
        .page_changed(page_changed),
        .pixel_data  (pixel_data)
    );

    // ---------------- reference model ----------------
    bit          hist [4][$];
    bit          m_acc [4];
    bit          m_rise [4];
    logic [3:0]  e_pulse;
    int          m_pend, m_sel, m_fade;
    logic        e_changed;
    logic [11:0] e_pix;

    function automatic int next_page(int p, bit go, bit cf, bit bk);
        bit ev [3];
        ev[0] = go; ev[1] = cf; ev[2] = bk;
        for (int i = 0; i < 3; i++)
            if (ev[i] && TRANS[p][i] >= 0) return TRANS[p][i];
        return p;
    endfunction

    function automatic logic [11:0] dim(logic [11:0] p, int s);
        logic [11:0] r;
        for (int c = 0; c < 3; c++) begin
            int v;
            v = int'(p[c*4 +: 4]);
            for (int j = 0; j < s; j++) v = v / 2;
            r[c*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    function automatic logic [11:0] page_pix(int p);
        case (p)
            MAIN:    return pix_main;
            PLAY:    return pix_play;
            PAUSE:   return pix_pause;
            default: return pix_over;
        endcase
    endfunction

    task automatic model_update();
        logic [11:0] np;
        logic [3:0]  np_pulse;
        int          old_pend;
        bit          all_same;
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                hist[k].delete();
                for (int j = 0; j < N + 2; j++) hist[k].push_back(1'b0);
                m_acc[k]  = 1'b0;
                m_rise[k] = 1'b0;
            end
            e_pulse = '0; m_pend = MAIN; m_sel = MAIN;
            m_fade = 0; e_changed = 1'b0; e_pix = '0;
            return;
        end
        np = dim(page_pix(m_sel), m_fade);
        old_pend = m_pend;
        e_changed = 1'b0;
        if (frame_done) begin
            e_changed = (m_pend != m_sel);
`ifdef PAGE_FADE_EN
            if (e_changed) m_fade = FADE;
            else if (m_fade > 0) m_fade--;
`endif
            m_sel = m_pend;
        end
        m_pend = next_page(old_pend, game_over, e_pulse[0], e_pulse[1]);
        for (int k = 0; k < 4; k++) begin
            np_pulse[k] = m_rise[k];
            m_rise[k] = 1'b0;
            hist[k].push_back(keys[k]);
            void'(hist[k].pop_front());
            all_same = 1'b1;
            for (int j = 0; j < N; j++)
                if (hist[k][j] == m_acc[k]) all_same = 1'b0;
            if (all_same) begin
                m_acc[k]  = ~m_acc[k];
                m_rise[k] = m_acc[k];
            end
        end
        e_pulse = np_pulse;
        e_pix = np;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic press(int k);
        keys[k] = 1'b1;
        repeat (8) tick();
        keys = '0;
        repeat (8) tick();
    endtask

    task automatic commit();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        keys = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (page_sel !== 2'd0 || pixel_data !== 12'h000 ||
                key_pulse !== 4'h0) begin
                nerr++;
                $display("FAIL reset sel=%0d pix=%h kp=%h want 0,000,0",
                         page_sel, pixel_data, key_pulse);
            end
        end
        keys = '0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_confirm_latency();
        keys[0] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            nvec++;
            if (key_pulse[0] !== (i == 7)) begin
                nerr++;
                $display("FAIL confirm_lat cyc=%0d kp0=%b want %b",
                         i, key_pulse[0], (i == 7));
            end
        end
        nvec++;
        if (page_sel !== 2'd0) begin
            nerr++;
            $display("FAIL defer sel=%0d want 0", page_sel);
        end
        keys = '0;
        commit();
        nvec++;
        if (page_sel !== 2'd1 || page_changed !== 1'b1) begin
            nerr++;
            $display("FAIL commit_play sel=%0d chg=%b want 1,1",
                     page_sel, page_changed);
        end
        tick();
        nvec++;
        if (page_changed !== 1'b0) begin
            nerr++;
            $display("FAIL chg_pulse chg=%b want 0", page_changed);
        end
        repeat (8) tick();
    endtask

    task automatic test_bounce();
        int cnt = 0, at = 0;
        for (int i = 1; i <= 20; i++) begin
            keys[0] = (i == 2 || i == 4) ? 1'b0 : 1'b1;
            tick();
            if (key_pulse[0]) begin
                cnt++;
                at = i;
            end
        end
        nvec++;
        if (cnt !== 1 || at !== 11) begin
            nerr++;
            $display("FAIL bounce pulses=%0d at=%0d want 1 at 11",
                     cnt, at);
        end
        keys = '0;
        repeat (8) tick();
    endtask

    task automatic test_gameover_priority();
        keys[1] = 1'b1;
        repeat (7) tick();
        nvec++;
        if (key_pulse[1] !== 1'b1) begin
            nerr++;
            $display("FAIL back_pulse kp=%h want bit1", key_pulse);
        end
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        keys = '0;
        commit();
        nvec++;
        if (page_sel !== 2'd3 || page_changed !== 1'b1) begin
            nerr++;
            $display("FAIL go_prio sel=%0d chg=%b want 3,1",
                     page_sel, page_changed);
        end
        repeat (8) tick();
    endtask

    task automatic test_pause_chain();
        int nchg = 0;
        press(0); commit();
        press(0); commit();
        press(1); commit();
        nvec++;
        if (page_sel !== 2'd2) begin
            nerr++;
            $display("FAIL to_pause sel=%0d want 2", page_sel);
        end
        press(0);
        press(1);
        commit();
        nvec++;
        if (page_sel !== 2'd2 || page_changed !== 1'b0) begin
            nerr++;
            $display("FAIL chain sel=%0d chg=%b want 2,0",
                     page_sel, page_changed);
        end
        press(1);
        frame_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            frame_done = 1'b0;
            if (page_changed) nchg++;
        end
        nvec++;
        if (page_sel !== 2'd0 || nchg !== 1) begin
            nerr++;
            $display("FAIL pause_back sel=%0d chg_n=%0d want 0,1",
                     page_sel, nchg);
        end
    endtask

    task automatic test_frame_edge_event();
        keys[0] = 1'b1;
        repeat (7) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        nvec++;
        if (page_sel !== 2'd0 || page_changed !== 1'b0) begin
            nerr++;
            $display("FAIL fd_event sel=%0d chg=%b want 0,0",
                     page_sel, page_changed);
        end
        keys = '0;
        repeat (8) tick();
        commit();
        nvec++;
        if (page_sel !== 2'd1 || page_changed !== 1'b1) begin
            nerr++;
            $display("FAIL fd_next sel=%0d chg=%b want 1,1",
                     page_sel, page_changed);
        end
    endtask

    task automatic test_pixel_mux();
        pix_main = 12'h123; pix_pause = 12'h456; pix_over = 12'h789;
`ifdef PAGE_FADE_EN
        pix_play = 12'hFFF;
        tick();
        nvec++;
        if (pixel_data !== 12'h111) begin
            nerr++;
            $display("FAIL fade pix=%h want 111", pixel_data);
        end
        repeat (3) commit();
`endif
        pix_play = 12'hABC;
        tick();
        nvec++;
        if (pixel_data !== 12'hABC) begin
            nerr++;
            $display("FAIL mux pix=%h want ABC", pixel_data);
        end
        pix_main = 12'h321;
        tick();
        nvec++;
        if (pixel_data !== 12'hABC) begin
            nerr++;
            $display("FAIL mux_iso pix=%h want ABC", pixel_data);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                keys = ($urandom_range(1) == 0) ? 4'h0
                     : 4'(1 << $urandom_range(3));
                hold = $urandom_range(12, 1);
            end
            hold--;
            frame_done = ($urandom_range(24) == 0);
            game_over  = ($urandom_range(19) == 0);
            pix_main  = 12'($urandom);
            pix_play  = 12'($urandom);
            pix_pause = 12'($urandom);
            pix_over  = 12'($urandom);
            rst_n = !(i >= 1500 && i < 1502);
            tick();
            nvec++;
            if ({key_pulse, page_sel, page_changed, pixel_data} !==
                {e_pulse, 2'(m_sel), e_changed, e_pix}) begin
                nerr++;
                $display("FAIL rand cyc=%0d got kp=%h sel=%0d chg=%b pix=%h want kp=%h sel=%0d chg=%b pix=%h",
                         i, key_pulse, page_sel, page_changed,
                         pixel_data, e_pulse, m_sel, e_changed, e_pix);
            end
        end
        frame_done = 1'b0;
        game_over = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; keys = '0; frame_done = 1'b0; game_over = 1'b0;
        pix_main = 12'h5A5; pix_play = 12'hA5A;
        pix_pause = 12'h3C3; pix_over = 12'hC3C;
        #2;
        test_reset();
        test_confirm_latency();
        test_bounce();
        test_gameover_priority();
        test_pause_chain();
        test_frame_edge_event();
        test_pixel_mux();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
